// File: rtl/apb_port_scheduler.sv
// Shares one APB master port between the write and read engines: per-beat arbitration
// with burst lock and bounded preemption, two-window PSEL decode, PREADY timeout.
module apb_port_scheduler #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter logic [19:0] SLV0_PAGE   = 20'h0001F,
  parameter logic [19:0] SLV1_PAGE   = 20'h0002F,
  parameter int          MAX_BURST   = 4,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_req_i,
  input  logic [ADDR_WIDTH-1:0] w_addr_i,
  input  logic [DATA_WIDTH-1:0] w_wdata_i,
  input  logic                  w_last_i,
  output logic                  w_done_o,
  output logic                  w_err_o,
  input  logic                  r_req_i,
  input  logic [ADDR_WIDTH-1:0] r_addr_i,
  input  logic                  r_last_i,
  output logic                  r_done_o,
  output logic [DATA_WIDTH-1:0] r_rdata_o,
  output logic                  r_err_o,
  output logic [1:0]            gnt_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic                  pwrite_o,
  output logic [1:0]            psel_o,
  output logic                  penable_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DERR   = 2'd3;

  localparam logic OWN_W = 1'b0;
  localparam logic OWN_R = 1'b1;

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 2);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic [1:0]            state_q, state_d;
  logic                  own_q, own_d;
  logic                  last_gnt_q, last_gnt_d;
  logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic                  locked_q, locked_d;
  logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic [1:0]            psel_q, psel_d;
  logic                  penable_q, penable_d;

  logic                  own_req, oth_req, grant, win, win_last;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [1:0]            dec_sel;
  logic                  tmo_hit, acc_done, beat_done, beat_err;

  assign own_req = (last_gnt_q == OWN_R) ? r_req_i : w_req_i;
  assign oth_req = (last_gnt_q == OWN_R) ? w_req_i : r_req_i;

  // Lock keeps the burst owner only until it has used MAX_BURST beats while the other waits.
  always_comb begin
    grant = 1'b0;
    win   = last_gnt_q;
    if (locked_q && own_req && ((beat_cnt_q < BURST_MAX) || !oth_req)) begin
      grant = 1'b1;
      win   = last_gnt_q;
    end else if (w_req_i && r_req_i) begin
      grant = 1'b1;
      win   = ~last_gnt_q;
    end else if (w_req_i) begin
      grant = 1'b1;
      win   = OWN_W;
    end else if (r_req_i) begin
      grant = 1'b1;
      win   = OWN_R;
    end
  end

  assign win_addr = (win == OWN_R) ? r_addr_i : w_addr_i;
  assign win_last = (win == OWN_R) ? r_last_i : w_last_i;

  always_comb begin
    dec_sel = 2'b00;
    if (win_addr[31:12] == SLV0_PAGE)      dec_sel = 2'b01;
    else if (win_addr[31:12] == SLV1_PAGE) dec_sel = 2'b10;
  end

  assign tmo_hit   = (TIMEOUT_CYC != 0) && !pready_i && (tmo_cnt_q == TMO_LAST);
  assign acc_done  = (state_q == ST_ACCESS) && (pready_i || tmo_hit);
  assign beat_done = acc_done || (state_q == ST_DERR);
  assign beat_err  = (state_q == ST_DERR) || !pready_i || pslverr_i;

  assign w_done_o  = beat_done && (own_q == OWN_W);
  assign r_done_o  = beat_done && (own_q == OWN_R);
  assign w_err_o   = w_done_o && beat_err;
  assign r_err_o   = r_done_o && beat_err;
  assign r_rdata_o = (r_done_o && (state_q == ST_ACCESS) && pready_i) ? prdata_i : '0;
  assign gnt_o     = (state_q == ST_IDLE) ? 2'b00 : ((own_q == OWN_R) ? 2'b10 : 2'b01);

  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign pwrite_o  = pwrite_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;

  always_comb begin
    state_d    = state_q;
    own_d      = own_q;
    last_gnt_d = last_gnt_q;
    beat_cnt_d = beat_cnt_q;
    locked_d   = locked_q;
    tmo_cnt_d  = tmo_cnt_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          own_d      = win;
          last_gnt_d = win;
          locked_d   = !win_last;
          tmo_cnt_d  = '0;
          if (win == last_gnt_q)
            beat_cnt_d = (beat_cnt_q < BURST_MAX) ? beat_cnt_q + 1'b1 : beat_cnt_q;
          else
            beat_cnt_d = BW'(1);
          if (dec_sel != 2'b00) begin
            state_d  = ST_SETUP;
            paddr_d  = win_addr;
            pwdata_d = (win == OWN_W) ? w_wdata_i : '0;
            pwrite_d = (win == OWN_W);
            psel_d   = dec_sel;
          end else begin
            state_d  = ST_DERR;
          end
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (acc_done) begin
          state_d   = ST_IDLE;
          paddr_d   = '0;
          pwdata_d  = '0;
          pwrite_d  = 1'b0;
          psel_d    = 2'b00;
          penable_d = 1'b0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      own_q      <= OWN_W;
      last_gnt_q <= OWN_R;
      beat_cnt_q <= '0;
      locked_q   <= 1'b0;
      tmo_cnt_q  <= '0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pwrite_q   <= 1'b0;
      psel_q     <= 2'b00;
      penable_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      last_gnt_q <= last_gnt_d;
      beat_cnt_q <= beat_cnt_d;
      locked_q   <= locked_d;
      tmo_cnt_q  <= tmo_cnt_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pwrite_q   <= pwrite_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
    end
  end

  // A pending beat must stay unchanged until its done pulse.
  a_w_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (w_req_i && !w_done_o) |=> (w_req_i && $stable(w_addr_i) && $stable(w_wdata_i) && $stable(w_last_i)));
  a_r_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (r_req_i && !r_done_o) |=> (r_req_i && $stable(r_addr_i) && $stable(r_last_i)));

endmodule
